mult_iter_param: RTL and testbench

MULT_ITER_PARAM -- requirements
Module: mult_iter_param

---
 rtl/mult_iter_pkg.sv | 19 +
 rtl/mult_iter_param_if.sv | 24 ++
 rtl/mult_iter_fsm.sv | 88 ++++++++
 rtl/mult_iter_param.sv | 106 ++++++++++
 tb/tb_mult_iter_param.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mult_iter_pkg.sv
// Shared definitions for the iterative digit-serial multiplier.
// Contents: FSM state enum, operand digit widths, WIDTH legality check.
package mult_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned A_DIG_W = 8;
    localparam int unsigned B_DIG_W = 16;

    // WIDTH must be a nonzero multiple of the wider (B) digit
    function automatic bit width_legal(input int unsigned w);
        return (w >= B_DIG_W) && ((w % B_DIG_W) == 0);
    endfunction

endpackage

// File: rtl/mult_iter_param_if.sv
// Request/response bundle of the iterative multiplier.
// master: drives start, signed_mode, a, b; observes busy, done, product.
// slave : the multiplier side (mirror of master).
interface mult_iter_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_iter_fsm.sv
// Control for the iterative multiplier: state, digit indices, busy/done.
// Ports: clk, reset (async active-low), start, na_last/nb_last (last digit
// index of each operand), busy/done (registered), i_idx/j_idx (registered
// digit indices), load_c/acc_c/neg_c (combinational datapath selects).
module mult_iter_fsm
    import mult_iter_pkg::*;
#(
    parameter int unsigned IW_A = 2,
    parameter int unsigned IW_B = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IW_A-1:0] na_last,
    input  logic [IW_B-1:0] nb_last,
    output logic            busy,
    output logic            done,
    output logic [IW_A-1:0] i_idx,
    output logic [IW_B-1:0] j_idx,
    output logic            load_c,
    output logic            acc_c,
    output logic            neg_c
);

    state_t          state_q, state_d;
    logic [IW_A-1:0] i_d;
    logic [IW_B-1:0] j_d;
    logic            busy_d, done_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_idx   <= '0;
            j_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_idx   <= i_d;
            j_idx   <= j_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state; i (A digit) is the inner loop, j (B digit) the outer
    always_comb begin
        state_d = state_q;
        i_d     = i_idx;
        j_d     = j_idx;
        done_d  = 1'b0;
        load_c  = 1'b0;
        acc_c   = 1'b0;
        neg_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_c = 1'b1;
                if (i_idx == na_last) begin
                    i_d = '0;
                    if (j_idx == nb_last) begin
                        state_d = FIN;
                    end else begin
                        j_d = j_idx + IW_B'(1);
                    end
                end else begin
                    i_d = i_idx + IW_A'(1);
                end
            end
            FIN: begin
                neg_c   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: rtl/mult_iter_param.sv
// Iterative multiplier: one 8x16-bit partial product per cycle, skipping
// leading zero digits; signed operands handled as sign + magnitude.
// Ports: clk, reset (async active-low), bus (mult_iter_param_if.slave):
// start/signed_mode/a/b in, busy/done/product out.
module mult_iter_param
    import mult_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mult_iter_param_if.slave       bus
);

    localparam int unsigned NA   = WIDTH / A_DIG_W;
    localparam int unsigned NB   = WIDTH / B_DIG_W;
    localparam int unsigned IW_A = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned IW_B = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned SW   = $clog2(PW);
    localparam int unsigned PPW  = A_DIG_W + B_DIG_W;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("mult_iter_param: WIDTH must be a multiple of 16 and >= 16");
    end

    logic [WIDTH-1:0]                mag_a_q, mag_b_q;
    logic                            sign_q;
    logic [PW-1:0]                   product_q;
    logic [WIDTH-1:0]                a_abs_c, b_abs_c;
    logic [NA-1:0][A_DIG_W-1:0]      a_dig;
    logic [NB-1:0][B_DIG_W-1:0]      b_dig;
    logic [IW_A-1:0]                 na_last_c, i_idx;
    logic [IW_B-1:0]                 nb_last_c, j_idx;
    logic [PPW-1:0]                  pp_c;
    logic [SW-1:0]                   shamt_c;
    logic [PW-1:0]                   pp_shift_c;
    logic                            load_c, acc_c, neg_c;

    // Magnitudes of the incoming operands (most negative maps to 2^(WIDTH-1))
    assign a_abs_c = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs_c = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign a_dig = mag_a_q;
    assign b_dig = mag_b_q;

    // Index of the highest nonzero digit; zero operand still takes one digit
    always_comb begin
        na_last_c = '0;
        for (int k = 0; k < NA; k++) begin
            if (a_dig[k] != '0) na_last_c = IW_A'(k);
        end
    end

    always_comb begin
        nb_last_c = '0;
        for (int k = 0; k < NB; k++) begin
            if (b_dig[k] != '0) nb_last_c = IW_B'(k);
        end
    end

    // Current partial product aligned to its digit position
    assign pp_c       = PPW'(a_dig[i_idx]) * PPW'(b_dig[j_idx]);
    assign shamt_c    = SW'(i_idx) * SW'(A_DIG_W) + SW'(j_idx) * SW'(B_DIG_W);
    assign pp_shift_c = PW'(pp_c) << shamt_c;

    mult_iter_fsm #(
        .IW_A (IW_A),
        .IW_B (IW_B)
    ) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.start),
        .na_last (na_last_c),
        .nb_last (nb_last_c),
        .busy    (bus.busy),
        .done    (bus.done),
        .i_idx   (i_idx),
        .j_idx   (j_idx),
        .load_c  (load_c),
        .acc_c   (acc_c),
        .neg_c   (neg_c)
    );

    // Operand capture, accumulation and final sign fix-up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else if (load_c) begin
            mag_a_q   <= a_abs_c;
            mag_b_q   <= b_abs_c;
            sign_q    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            product_q <= '0;
        end else if (acc_c) begin
            product_q <= product_q + pp_shift_c;
        end else if (neg_c && sign_q) begin
            product_q <= -product_q;
        end
    end

    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// Self-checking bench for mult_iter_param (WIDTH=32): directed vector table
// plus hand-written reset-abort, back-to-back and start-while-busy sequences.
module tb_mult_iter_param;

    logic clk;
    logic reset;

    mult_iter_param_if #(.WIDTH(32)) bus ();

    mult_iter_param #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prod;
        int          lat;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Drives start in cycle 0 (caller is before the sampling edge); returns at
    // the done cycle's falling edge. pulse_mask bit n re-asserts start with
    // junk operands in cycle n.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] pulse_mask, input string tag,
                         output int lat, output logic [63:0] prod);
        logic bad_busy;
        bad_busy        = 1'b0;
        lat             = -1;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sgn;
        bus.start       = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (pulse_mask[cyc]) begin
                bus.start       = 1'b1;
                bus.a           = 32'hFFFF_FFFF;
                bus.b           = 32'hFFFF_FFFF;
                bus.signed_mode = ~sgn;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) check({tag, " product_cleared"}, bus.product, 64'h0);
            if (bus.done) begin
                lat = cyc;
                break;
            end
            if (!bus.busy) bad_busy = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, " busy_gap"}, 64'(bad_busy), 64'h0);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'h0);
        prod = bus.product;
    endtask

    initial begin
        int          lat;
        logic [63:0] prod;
        logic        saw_done, saw_busy;

        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{32'h0000_00FF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_00FE_FF01, 3};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 10};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3};
        vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 10};
        vecs[4]  = '{32'h0000_0000, 32'h0000_1234, 1'b0, 64'h0000_0000_0000_0000, 3};
        vecs[5]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 8};
        vecs[6]  = '{32'hFFFF_FF00, 32'h0000_0100, 1'b1, 64'hFFFF_FFFF_FFFF_0000, 4};
        vecs[7]  = '{32'h8000_0000, 32'h0000_0003, 1'b0, 64'h0000_0001_8000_0000, 6};
        vecs[8]  = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 3};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 10};
        vecs[10] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, 10};
        vecs[11] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 64'h0000_0000_0000_0000, 4};

        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        #1;
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset done", 64'(bus.done), 64'h0);
        check("reset product", bus.product, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            do_op(vecs[v].a, vecs[v].b, vecs[v].sgn, 32'h0, $sformatf("vec%0d", v), lat, prod);
            check($sformatf("vec%0d product", v), prod, vecs[v].prod);
            check($sformatf("vec%0d latency", v), 64'(lat), 64'(vecs[v].lat));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", v), 64'(bus.done), 64'h0);
            check($sformatf("vec%0d product_held", v), bus.product, vecs[v].prod);
        end

        // Reset in cycle 4 of an 8-partial operation
        @(negedge clk);
        bus.a           = 32'h0101_0101;
        bus.b           = 32'h0001_0001;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'h0);
        check("abort done", 64'(bus.done), 64'h0);
        check("abort product", bus.product, 64'h0);
        @(negedge clk);
        reset    = 1'b1;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
        end
        check("abort no_done_after", 64'(saw_done), 64'h0);
        check("abort stays_idle", 64'(saw_busy), 64'h0);

        // Back-to-back: second start issued during the first done cycle
        @(negedge clk);
        do_op(32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0, "b2b_first", lat, prod);
        check("b2b_first product", prod, 64'h0000_0000_0000_000F);
        check("b2b_first latency", 64'(lat), 64'd3);
        do_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0, "b2b_second", lat, prod);
        check("b2b_second product", prod, 64'hFFFF_FFFF_FFFF_FFFA);
        check("b2b_second latency", 64'(lat), 64'd3);

        // start pulsed in cycles 2 and 5 of a 10-cycle operation is ignored
        @(negedge clk);
        do_op(32'h0101_0101, 32'h0001_0001, 1'b0, 32'h0000_0024, "busy_start", lat, prod);
        check("busy_start product", prod, 64'h0000_0101_0202_0101);
        check("busy_start latency", 64'(lat), 64'd10);
        repeat (3) @(negedge clk);
        check("busy_start idle_after", 64'(bus.busy), 64'h0);
        check("busy_start product_final", bus.product, 64'h0000_0101_0202_0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
